// File: rtl/signed_sum_accumulator_if.sv
// Stream bus for signed_sum_accumulator: 5-bit signed sum in, saturated 8-bit block result out.
interface signed_sum_accumulator_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [4:0] in_sum;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_acc;
  logic              out_sat;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_sat
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_sat
  );
endinterface

// File: rtl/signed_sum_accumulator.sv
// Accumulates N_SAMPLES signed sums with per-add 8-bit saturation, then holds the
// block result until the downstream consumes it.
module signed_sum_accumulator #(
  parameter int N_SAMPLES = 16
) (
  input logic                    clk,
  input logic                    rst,
  signed_sum_accumulator_if.slave bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] CNT_LAST = 8'(N_SAMPLES);

  state_t            state, state_nxt;
  logic signed [7:0] acc, acc_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              sat, sat_nxt;

  logic signed [8:0] sum9;
  logic [7:0]        cnt_inc;
  logic              ovf_pos, ovf_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      sat   <= sat_nxt;
    end
  end

  // 9-bit sum cannot wrap: operands span -144..+142; bits [8:7] disagreeing means clip.
  assign sum9    = {acc[7], acc} + {{4{bus.in_sum[4]}}, bus.in_sum};
  assign ovf_pos = ~sum9[8] &  sum9[7];
  assign ovf_neg =  sum9[8] & ~sum9[7];
  assign cnt_inc = cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sat_nxt   = sat;
    unique case (state)
      ACCUM: begin
        if (bus.in_valid) begin
          if (ovf_pos)      acc_nxt = 8'sd127;
          else if (ovf_neg) acc_nxt = -8'sd128;
          else              acc_nxt = sum9[7:0];
          sat_nxt = sat | ovf_pos | ovf_neg;
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_LAST) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          sat_nxt   = 1'b0;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_acc   = acc;
  assign bus.out_sat   = sat;

endmodule
